// File: rtl/sr04_pkg.sv
// rtl/sr04_pkg.sv - shared state encoding and 50 MHz timing defaults for the HC-SR04 blocks
package sr04_pkg;

    localparam logic [2:0] SR04_IDLE      = 3'd0;
    localparam logic [2:0] SR04_TRIG      = 3'd1;
    localparam logic [2:0] SR04_WAIT_ECHO = 3'd2;
    localparam logic [2:0] SR04_ECHO_HIGH = 3'd3;
    localparam logic [2:0] SR04_HOLDOFF   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = SR04_IDLE,
        ST_TRIG      = SR04_TRIG,
        ST_WAIT_ECHO = SR04_WAIT_ECHO,
        ST_ECHO_HIGH = SR04_ECHO_HIGH,
        ST_HOLDOFF   = SR04_HOLDOFF
    } sr04_state_t;

    localparam int unsigned SR04_TRIG_CYCLES   = 500;
    localparam int unsigned SR04_PERIOD_CYCLES = 3_000_000;
    localparam int unsigned SR04_ECHO_TIMEOUT  = 1_500_000;
    localparam int unsigned SR04_CNT_W         = 22;

endpackage

// File: rtl/sr04_echo_sync.sv
// rtl/sr04_echo_sync.sv - 2-flop echo synchroniser with single-cycle rise/fall pulses
module sr04_echo_sync (
    input  logic clk,
    input  logic rst,
    input  logic echo,
    output logic echo_s,
    output logic echo_rise,
    output logic echo_fall
);

    logic echo_meta;
    logic echo_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            echo_d    <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_s    <= echo_meta;
            echo_d    <= echo_s;
        end
    end

    // Edges are taken from the second flop so they line up with echo_s.
    assign echo_rise = echo_s & ~echo_d;
    assign echo_fall = ~echo_s & echo_d;

endmodule

// File: rtl/sr04_trigger_gen.sv
// rtl/sr04_trigger_gen.sv - HC-SR04 trigger pulse, measurement pacing and echo timeout
module sr04_trigger_gen
    import sr04_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES   = SR04_TRIG_CYCLES,
    parameter int unsigned PERIOD_CYCLES = SR04_PERIOD_CYCLES,
    parameter int unsigned ECHO_TIMEOUT  = SR04_ECHO_TIMEOUT,
    parameter int unsigned CNT_W         = SR04_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic start,
    input  logic echo,
    output logic trig,
    output logic busy,
    output logic meas_done,
    output logic timeout
);

    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ECHO_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_EXIT  = CNT_W'(PERIOD_CYCLES - 2);

    sr04_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             echo_s;
    logic             echo_rise;
    logic             echo_fall;

    sr04_echo_sync u_echo_sync (
        .clk       (clk),
        .rst       (rst),
        .echo      (echo),
        .echo_s    (echo_s),
        .echo_rise (echo_rise),
        .echo_fall (echo_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            trig       <= 1'b0;
            busy       <= 1'b0;
            meas_done  <= 1'b0;
            timeout    <= 1'b0;
            cnt        <= '0;
            period_cnt <= '0;
        end else begin
            meas_done <= 1'b0;
            timeout   <= 1'b0;
            if (period_cnt != PERIOD_LAST)
                period_cnt <= period_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    // A stuck-high echo blocks new triggers until the line is seen low.
                    if ((enable || start) && !echo_s) begin
                        state      <= ST_TRIG;
                        trig       <= 1'b1;
                        busy       <= 1'b1;
                        cnt        <= '0;
                        period_cnt <= '0;
                    end
                end
                ST_TRIG: begin
                    if (cnt == TRIG_LAST) begin
                        state <= ST_WAIT_ECHO;
                        trig  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_ECHO: begin
                    if (cnt == TIMEOUT_LAST) begin
                        state   <= ST_HOLDOFF;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (echo_rise)
                            state <= ST_ECHO_HIGH;
                    end
                end
                ST_ECHO_HIGH: begin
                    // The limit is tested first so a coincident echo fall reports a timeout.
                    if (cnt == TIMEOUT_LAST) begin
                        state   <= ST_HOLDOFF;
                        timeout <= 1'b1;
                    end else if (echo_fall) begin
                        state     <= ST_HOLDOFF;
                        meas_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    // Leave one cycle early so the IDLE cycle lands on the period boundary.
                    if (period_cnt == PERIOD_EXIT || period_cnt == PERIOD_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    trig  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
